// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request / HI-LO bus between the pipeline and the
//                multiply-divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_div_unit_if;
  logic        start;   // request a new operation
  logic [1:0]  op;      // 00 mult, 01 multu, 10 div, 11 divu
  logic [31:0] a;       // rs operand
  logic [31:0] b;       // rt operand
  logic        hi_we;   // mthi strobe
  logic        lo_we;   // mtlo strobe
  logic        busy;    // operation in progress
  logic        done;    // one-cycle result pulse
  logic [31:0] hi;      // HI register
  logic [31:0] lo;      // LO register

  modport master (
    output start, op, a, b, hi_we, lo_we,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative 32-bit multiply / divide unit with HI/LO
//                registers. 32 shift-add or restoring-divide steps on
//                operand magnitudes, sign fix-up in a final cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_unit (
  input  wire logic          clk,
  input  wire logic          rst,
  mult_div_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [5:0] c_LAST_ITER = 6'd31;

  state_t       r_state;
  state_t       w_next;

  logic [5:0]   r_cnt;
  logic         r_is_div;
  logic [31:0]  r_opnd;     // multiplicand magnitude or divisor magnitude
  logic [64:0]  r_acc;      // mult: {carry, hi, multiplier}; div: {rem, dividend}
  logic [31:0]  r_a;        // original dividend, returned on divide-by-zero
  logic         r_divz;
  logic         r_neg_p;    // negate 64-bit product
  logic         r_neg_q;    // negate quotient
  logic         r_neg_r;    // negate remainder
  logic [31:0]  r_hi;
  logic [31:0]  r_lo;
  logic         r_done;

  // Operand magnitudes; only the signed ops (op[0]==0) look at sign bits
  logic         w_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [31:0]  w_a_mag;
  logic [31:0]  w_b_mag;

  // Iteration datapath
  logic [32:0]  w_msum;
  logic [64:0]  w_mult_next;
  logic [64:0]  w_dshift;
  logic [33:0]  w_dtrial;
  logic [64:0]  w_div_next;

  // Final results after sign fix
  logic [63:0]  w_prod;
  logic [31:0]  w_quot;
  logic [31:0]  w_rem;
  logic [31:0]  w_res_hi;
  logic [31:0]  w_res_lo;

  assign w_signed = ~bus.op[0];
  assign w_a_neg  = w_signed & bus.a[31];
  assign w_b_neg  = w_signed & bus.b[31];
  assign w_a_mag  = w_a_neg ? (~bus.a + 32'd1) : bus.a;
  assign w_b_mag  = w_b_neg ? (~bus.b + 32'd1) : bus.b;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_msum      = r_acc[64:32] + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mult_next = {1'b0, w_msum, r_acc[31:1]};

  // Restoring divide: shift in the next dividend bit, keep the trial
  // difference only if it did not borrow. The partial remainder needs
  // 33 bits because the divisor may use all 32.
  assign w_dshift   = {r_acc[63:0], 1'b0};
  assign w_dtrial   = {1'b0, w_dshift[64:32]} - {2'b00, r_opnd};
  assign w_div_next = w_dtrial[33] ? w_dshift
                                   : {w_dtrial[32:0], w_dshift[31:1], 1'b1};

  assign w_prod   = r_neg_p ? (~r_acc[63:0] + 64'd1) : r_acc[63:0];
  assign w_quot   = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem    = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  // Result selection, with divide-by-zero overriding the iterated value
  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_is_div) begin
      if (r_divz) begin
        w_res_hi = r_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)            w_next = ST_RUN;
      ST_RUN:  if (r_cnt == c_LAST_ITER) w_next = ST_FIN;
      ST_FIN:                            w_next = ST_IDLE;
      default:                           w_next = ST_IDLE;
    endcase
  end

  // Operand capture and per-edge iteration of the working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_is_div <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc    <= 65'd0;
      r_a      <= 32'd0;
      r_divz   <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_cnt    <= 6'd0;
            r_is_div <= bus.op[1];
            r_opnd   <= bus.op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {33'd0, (bus.op[1] ? w_a_mag : w_b_mag)};
            r_a      <= bus.a;
            r_divz   <= bus.op[1] & (bus.b == 32'd0);
            r_neg_p  <= ~bus.op[1] & (w_a_neg ^ w_b_neg);
            r_neg_q  <=  bus.op[1] & (w_a_neg ^ w_b_neg);
            r_neg_r  <=  bus.op[1] & w_a_neg;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          r_acc <= r_is_div ? w_div_next : w_mult_next;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: direct writes only when idle, result write in the final cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == ST_IDLE) begin
      if (bus.hi_we) r_hi <= bus.a;
      if (bus.lo_we) r_lo <= bus.a;
    end else if (r_state == ST_FIN) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end
  end

  // Completion pulse for the cycle after the result write
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == ST_FIN);
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Scoreboard bench for mult_div_unit: directed corner cases
//                plus random operations against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];        // expected {hi, lo} per accepted operation
  logic [31:0] last_hi;
  logic [31:0] last_lo;
  logic        prev_done = 1'b0;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  // Monitor: every done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      logic [63:0] e;
      if (prev_done) check("done_width", 64'd2, 64'd1);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
        check("result_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one operation and measure its busy window. inject drives
  // start/hi_we/lo_we during busy; wr_too adds hi_we/lo_we to the start cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, input bit wr_too);
    logic [63:0] e;
    int n;
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.hi_we = wr_too;
    bus.lo_we = wr_too;
    e = ref_model(o, x, y);
    sb.push_back(e);
    last_hi = e[63:32];
    last_lo = e[31:0];
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (wr_too) check("write_with_start", {bus.hi, bus.lo}, {x, x});
    bus.a  = $urandom;
    bus.b  = $urandom;
    bus.op = 2'($urandom);
    n = 0;
    while (bus.busy && n < 100) begin
      if (inject) begin
        bus.start = (n < 30);
        bus.hi_we = (n < 30);
        bus.lo_we = (n < 30);
        bus.a     = $urandom;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("busy_cycles", 64'(n), 64'd33);
    check("done_after_busy", {63'd0, bus.done}, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0000_0000; sp[1] = 32'h0000_0001; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
    if ($urandom_range(3) == 0) return $urandom_range(200);
    return $urandom;
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {30'd0, bus.busy, bus.done, bus.hi}, 64'd0);
    check("reset_lo", {32'd0, bus.lo}, 64'd0);

    // Directed corner cases
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    do_op(2'b11, 32'd100,       32'd7,         1'b0, 1'b0);
    do_op(2'b11, 32'h0000_0064, 32'd0,         1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0005, 32'd0,         1'b0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // Direct HI/LO writes while idle
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.a     = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi", {bus.hi, bus.lo}, {32'h1234_5678, last_lo});
    bus.lo_we = 1'b1;
    bus.a     = 32'hCAFE_F00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo", {bus.hi, bus.lo}, {32'h1234_5678, 32'hCAFE_F00D});

    // Activity during busy must not disturb the result or queue a start
    do_op(2'b10, 32'hFFFF_FF00, 32'h0000_0013, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("no_queued_start", {63'd0, bus.busy}, 64'd0);
    check("hold_after_done", {bus.hi, bus.lo}, {last_hi, last_lo});

    // Write together with start: write lands at E0, result overwrites later
    do_op(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b1);

    // Reset mid-run, colliding with start and writes
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("reset_mid_run", {30'd0, bus.busy, bus.done, bus.hi}, 64'd0);
    check("reset_mid_run_lo", {32'd0, bus.lo}, 64'd0);
    repeat (40) @(negedge clk);
    check("no_done_after_reset", {63'd0, bus.busy}, 64'd0);
    do_op(2'b00, 32'd5, 32'd6, 1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), pick(), pick(), ($urandom_range(7) == 0), ($urandom_range(7) == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
